// File: rtl/uart_telemetria_tx.sv
// uart_telemetria_tx
//
// Sends a 5-byte status frame to the host over 8N1 UART on a send request.
// The frame is {HEADER, humidity high nibble, humidity low byte, flags/plant
// type, 8-bit additive checksum}. Bit timing is derived from clk.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   enviar      send request, accepted when not busy
//   humedad     12-bit humidity value, snapshotted on acceptance
//   tipoPlanta  4-bit plant type, snapshotted on acceptance
//   regar       watering-request flag, snapshotted on acceptance
//   activarB    pump-active flag, snapshotted on acceptance
//   tx          serial output, idle high, driven from a flop
//   ocupado     high while a frame is being shifted out
//   hecho       one-cycle pulse in the cycle after the last stop bit

module uart_telemetria_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enviar,
    input  logic [11:0] humedad,
    input  logic [3:0]  tipoPlanta,
    input  logic        regar,
    input  logic        activarB,
    output logic        tx,
    output logic        ocupado,
    output logic        hecho
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    localparam logic [15:0] LastTick = 16'(CLKS_PER_BIT - 1);

    state_e      state_q;
    logic [15:0] tick_q;
    logic [2:0]  bit_q;
    logic [2:0]  byte_q;
    logic        tx_q;
    logic        ocupado_q;
    logic        hecho_q;

    // Snapshot of the reported values, frozen for the whole frame.
    logic [11:0] hum_q;
    logic [3:0]  tipo_q;
    logic        regar_q;
    logic        bomba_q;

    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  chk;
    logic [7:0]  cur_byte;
    logic [2:0]  next_bit;
    logic        bit_end;
    logic        accept;

    assign b1       = {4'h0, hum_q[11:8]};
    assign b2       = hum_q[7:0];
    assign b3       = {2'b00, regar_q, bomba_q, tipo_q};
    // 8-bit sum, carries out of bit 7 are dropped.
    assign chk      = HEADER + b1 + b2 + b3;
    assign next_bit = bit_q + 3'd1;
    assign bit_end  = (tick_q == LastTick);
    assign accept   = enviar && !ocupado_q;

    always_comb begin
        cur_byte = HEADER;
        case (byte_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
            default: cur_byte = chk;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= 16'd0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            hecho_q   <= 1'b0;
            hum_q     <= 12'd0;
            tipo_q    <= 4'd0;
            regar_q   <= 1'b0;
            bomba_q   <= 1'b0;
        end else begin
            hecho_q <= 1'b0;
            case (state_q)
                // The DONE cycle also accepts, so frames can run back-to-back.
                StIdle, StDone: begin
                    if (accept) begin
                        hum_q     <= humedad;
                        tipo_q    <= tipoPlanta;
                        regar_q   <= regar;
                        bomba_q   <= activarB;
                        state_q   <= StStart;
                        ocupado_q <= 1'b1;
                        tx_q      <= 1'b0;
                        tick_q    <= 16'd0;
                        bit_q     <= 3'd0;
                        byte_q    <= 3'd0;
                    end else begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        tick_q  <= 16'd0;
                        bit_q   <= 3'd0;
                        tx_q    <= cur_byte[0];
                        state_q <= StData;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        tick_q <= 16'd0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= next_bit;
                            tx_q  <= cur_byte[next_bit];
                        end
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        tick_q <= 16'd0;
                        if (byte_q == 3'd4) begin
                            byte_q    <= 3'd0;
                            tx_q      <= 1'b1;
                            ocupado_q <= 1'b0;
                            hecho_q   <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            byte_q  <= byte_q + 3'd1;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    tx_q      <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign ocupado = ocupado_q;
    assign hecho   = hecho_q;

endmodule

// File: tb/tb_uart_telemetria_tx.sv
// Bench for uart_telemetria_tx with CLKS_PER_BIT=4. A frame-level model
// predicts tx/ocupado/hecho every cycle from the cycle count since
// acceptance; directed runs also record the line and decode it against
// hand-computed bytes.

module tb_uart_telemetria_tx;

    localparam int C  = 4;
    localparam int FB = 50 * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enviar = 1'b0;
    logic [11:0] humedad = 12'h000;
    logic [3:0]  tipoPlanta = 4'h0;
    logic        regar = 1'b0;
    logic        activarB = 1'b0;
    logic        tx;
    logic        ocupado;
    logic        hecho;

    always #5 clk = ~clk;

    uart_telemetria_tx #(
        .CLKS_PER_BIT(C),
        .HEADER      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enviar    (enviar),
        .humedad   (humedad),
        .tipoPlanta(tipoPlanta),
        .regar     (regar),
        .activarB  (activarB),
        .tx        (tx),
        .ocupado   (ocupado),
        .hecho     (hecho)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected line bits of a whole frame, bit 0 first on the wire.
    function automatic logic [49:0] frame_bits(input logic [11:0] h, input logic [3:0] t,
                                               input logic r, input logic a);
        logic [7:0]  b [5];
        logic [49:0] f;
        int          s;
        b[0] = 8'hA5;
        b[1] = {4'h0, h[11:8]};
        b[2] = h[7:0];
        b[3] = {2'b00, r, a, t};
        s    = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
        b[4] = 8'(s % 256);
        f    = '0;
        for (int k = 0; k < 5; k++) begin
            f[k*10] = 1'b0;
            for (int j = 0; j < 8; j++) f[k*10+1+j] = b[k][j];
            f[k*10+9] = 1'b1;
        end
        return f;
    endfunction

    // Model: m_n is the cycle number relative to the acceptance edge.
    logic        m_active = 1'b0;
    int          m_n      = 0;
    logic [49:0] m_frame  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_n      <= 0;
        end else if (enviar && !(m_active && m_n >= 1 && m_n <= FB)) begin
            m_active <= 1'b1;
            m_n      <= 1;
            m_frame  <= frame_bits(humedad, tipoPlanta, regar, activarB);
        end else if (m_active) begin
            if (m_n == FB + 1) begin
                m_active <= 1'b0;
                m_n      <= 0;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic etx;
        logic eoc;
        logic eh;
        if (m_active && m_n >= 1 && m_n <= FB) begin
            etx = m_frame[(m_n - 1) / C];
            eoc = 1'b1;
            eh  = 1'b0;
        end else if (m_active && m_n == FB + 1) begin
            etx = 1'b1;
            eoc = 1'b0;
            eh  = 1'b1;
        end else begin
            etx = 1'b1;
            eoc = 1'b0;
            eh  = 1'b0;
        end
        chk("model_tx", 32'(tx), 32'(etx));
        chk("model_ocupado", 32'(ocupado), 32'(eoc));
        chk("model_hecho", 32'(hecho), 32'(eh));
    end

    logic rec_tx [1:260];
    logic rec_h  [1:260];
    logic rec_oc [1:260];

    // Accept a frame, then record ncyc cycles while applying per-cycle stimulus.
    task automatic run(input int ncyc, input int rst_at, input int hum_at,
                       input int env_a, input int env_b, input bit hold);
        @(negedge clk);
        enviar = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            rec_tx[n] = tx;
            rec_h[n]  = hecho;
            rec_oc[n] = ocupado;
            if (n == hum_at) humedad = 12'hFFF;
            enviar = hold || (n == env_a) || (n == env_b);
            rst    = (n == rst_at);
        end
        enviar = 1'b0;
        rst    = 1'b0;
    endtask

    function automatic logic [7:0] rx_byte(input int b);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = rec_tx[b*40 + 6 + 4*j];
        return v;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("%s_start%0d", tag, b), 32'(rec_tx[b*40 + 2]), 32'd0);
            chk($sformatf("%s_byte%0d", tag, b), 32'(rx_byte(b)), 32'(e[b]));
            chk($sformatf("%s_stop%0d", tag, b), 32'(rec_tx[b*40 + 38]), 32'd1);
        end
    endtask

    function automatic int count_hecho(input int last);
        int c = 0;
        for (int n = 1; n <= last; n++) if (rec_h[n] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three edges, then released.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_ocupado", 32'(ocupado), 32'd0);
            chk("rst_hecho", 32'(hecho), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_ocupado", 32'(ocupado), 32'd0);
        chk("post_rst_hecho", 32'(hecho), 32'd0);
        repeat (2) @(negedge clk);

        // Basic frame with snapshot change at 5 and busy requests at 10, 120.
        humedad = 12'h3A7; tipoPlanta = 4'h5; regar = 1'b1; activarB = 1'b0;
        run(205, 0, 5, 10, 120, 1'b0);
        check_frame("basic", 8'hA5, 8'h03, 8'hA7, 8'h25, 8'h74);
        chk("basic_tx_c1", 32'(rec_tx[1]), 32'd0);
        chk("basic_oc_c1", 32'(rec_oc[1]), 32'd1);
        chk("basic_tx_c4", 32'(rec_tx[4]), 32'd0);
        chk("basic_tx_c5", 32'(rec_tx[5]), 32'd1);
        chk("basic_oc_c200", 32'(rec_oc[200]), 32'd1);
        chk("basic_hecho_c201", 32'(rec_h[201]), 32'd1);
        chk("basic_oc_c201", 32'(rec_oc[201]), 32'd0);
        chk("basic_tx_c201", 32'(rec_tx[201]), 32'd1);
        chk("basic_hecho_count", 32'(count_hecho(205)), 32'd1);
        chk("busy_idle_c205", 32'(rec_oc[205]), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back with enviar held high.
        humedad = 12'h3A7;
        run(202, 0, 0, 0, 0, 1'b1);
        chk("b2b_hecho_c201", 32'(rec_h[201]), 32'd1);
        chk("b2b_tx_c201", 32'(rec_tx[201]), 32'd1);
        chk("b2b_tx_c202", 32'(rec_tx[202]), 32'd0);
        chk("b2b_oc_c202", 32'(rec_oc[202]), 32'd1);
        repeat (210) @(negedge clk);

        // Checksum wrap.
        humedad = 12'hFFF; tipoPlanta = 4'hF; regar = 1'b1; activarB = 1'b1;
        run(205, 0, 0, 0, 0, 1'b0);
        check_frame("wrap", 8'hA5, 8'h0F, 8'hFF, 8'h3F, 8'hF2);
        chk("wrap_hecho_c201", 32'(rec_h[201]), 32'd1);
        repeat (3) @(negedge clk);

        // Abort with reset sampled at the end of cycle 90.
        run(215, 90, 0, 0, 0, 1'b0);
        begin
            int hi = 0;
            for (int n = 91; n <= 215; n++) if (rec_tx[n] === 1'b1) hi++;
            chk("abort_tx_high", 32'(hi), 32'd125);
        end
        chk("abort_tx_c90", 32'(rec_tx[90]), 32'(rec_tx[89]));
        chk("abort_oc_c91", 32'(rec_oc[91]), 32'd0);
        chk("abort_hecho_count", 32'(count_hecho(215)), 32'd0);
        repeat (3) @(negedge clk);

        // Fresh frame after abort restarts at the header.
        run(205, 0, 0, 0, 0, 1'b0);
        check_frame("fresh", 8'hA5, 8'h0F, 8'hFF, 8'h3F, 8'hF2);
        chk("fresh_hecho_c201", 32'(rec_h[201]), 32'd1);
        chk("fresh_hecho_count", 32'(count_hecho(205)), 32'd1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
